aes_round_ctrl: RTL

Iterative AES-128 encryption round sequencer. Accepts one plaintext block over a valid/ready handshake, holds the 4x4 byte state, and drives the shared round datapath one round per cycle: first round (AddRoundKey), middle rounds, final round. It requests round keys from the key schedule by index and returns the ciphertext over a valid/ready handshake. It sits between the block I/O and the round datapath (firstround / middle round / final round modules muxed by `round_sel`).

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_round_ctrl_if.sv | 30 +++
 rtl/aes_round_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types: round count, datapath select, controller states, byte state.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;

    typedef enum logic [1:0] {
        RselNone  = 2'd0,
        RselFirst = 2'd1,
        RselMid   = 2'd2,
        RselFinal = 2'd3
    } round_sel_t;

    typedef enum logic [2:0] {
        CtrlIdle  = 3'd0,
        CtrlFirst = 3'd1,
        CtrlMid   = 3'd2,
        CtrlFinal = 3'd3,
        CtrlDone  = 3'd4
    } ctrl_state_t;

    // [row][col][bit]; byte [3][3] is the most significant.
    typedef logic [3:0][3:0][7:0] aes_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block I/O bus: plaintext in and ciphertext out, each over valid/ready.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_block;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_block;

    modport master (
        output in_valid,
        output in_block,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_block
    );

    modport slave (
        input  in_valid,
        input  in_block,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_block
    );

endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: holds the state, steps the shared round
// datapath one round per cycle and hands the ciphertext back over valid/ready.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.slave  bus,
    output aes_state_t       state_q,
    output round_sel_t       round_sel,
    output logic [3:0]       rk_idx,
    input  logic             key_valid,
    input  aes_state_t       rnd_result,
    output logic             busy
);

    localparam logic [2:0] StIdle  = 3'(CtrlIdle);
    localparam logic [2:0] StFirst = 3'(CtrlFirst);
    localparam logic [2:0] StMid   = 3'(CtrlMid);
    localparam logic [2:0] StFinal = 3'(CtrlFinal);
    localparam logic [2:0] StDone  = 3'(CtrlDone);

    localparam logic [3:0] LastMid  = 4'(NR - 1);
    localparam logic [3:0] LastRnd  = 4'(NR);

    logic [2:0] fsm_q, fsm_d;
    logic [3:0] round_q, round_d;
    aes_state_t state_d;

    // Next-state: FSM, round counter and state register; key_valid low stalls.
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        case (fsm_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = bus.in_block;
                    round_d = 4'd0;
                    fsm_d   = StFirst;
                end
            end
            StFirst: begin
                if (key_valid) begin
                    state_d = rnd_result;
                    round_d = 4'd1;
                    fsm_d   = StMid;
                end
            end
            StMid: begin
                if (key_valid) begin
                    state_d = rnd_result;
                    if (round_q == LastMid) begin
                        round_d = LastRnd;
                        fsm_d   = StFinal;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            StFinal: begin
                if (key_valid) begin
                    state_d = rnd_result;
                    fsm_d   = StDone;
                end
            end
            StDone: begin
                // State is left intact so out_block stays readable after the handshake.
                if (bus.out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= StIdle;
            round_q <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

    // Outputs decoded from the FSM state only; in_ready never looks at in_valid.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        round_sel     = RselNone;
        rk_idx        = 4'd0;
        busy          = 1'b1;
        case (fsm_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
            end
            StFirst: round_sel = RselFirst;
            StMid: begin
                round_sel = RselMid;
                rk_idx    = round_q;
            end
            StFinal: begin
                round_sel = RselFinal;
                rk_idx    = LastRnd;
            end
            StDone: bus.out_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign bus.out_block = state_q;

endmodule
